// File: rtl/decode_hazard_if.sv
// Fetch/execute-facing bundle of the decode hazard unit; the stall and flush
// counter signals exist only when HAZARD_STATS_EN is defined.
interface decode_hazard_if #(
   parameter int unsigned ADDR_W = 16
`ifdef HAZARD_STATS_EN
   ,parameter int unsigned CNT_W = 16
`endif
);
   logic [31:0]       ins;
   logic [ADDR_W-1:0] current_address;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_target;
   logic              stall;
   logic              stall_pm;
   logic              pc_mux_sel;
   logic [ADDR_W-1:0] jmp_loc;
   logic [31:0]       id_ins;
   logic [ADDR_W-1:0] id_pc;
   logic              id_valid;
   logic [31:0]       ex_ins;
   logic [ADDR_W-1:0] ex_pc;
   logic              ex_valid;
`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0]  stall_count;
   logic [CNT_W-1:0]  flush_count;
`endif

   modport master (
      output ins, current_address, branch_taken, branch_target,
      input  stall, stall_pm, pc_mux_sel, jmp_loc,
      input  id_ins, id_pc, id_valid, ex_ins, ex_pc, ex_valid
`ifdef HAZARD_STATS_EN
      ,input stall_count, flush_count
`endif
   );

   modport slave (
      input  ins, current_address, branch_taken, branch_target,
      output stall, stall_pm, pc_mux_sel, jmp_loc,
      output id_ins, id_pc, id_valid, ex_ins, ex_pc, ex_valid
`ifdef HAZARD_STATS_EN
      ,output stall_count, flush_count
`endif
   );
endinterface

// File: rtl/decode_hazard_unit.sv
// Decode front end: IF/ID and ID/EX registers, load-use stall, J/JAL and
// taken-branch redirect with flush. Optional counters under HAZARD_STATS_EN.
module decode_hazard_unit #(
   parameter int unsigned ADDR_W   = 16,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
`ifdef HAZARD_STATS_EN
   ,parameter int unsigned CNT_W   = 16
`endif
) (
   input  logic           clk,
   input  logic           reset,
   decode_hazard_if.slave bus
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef enum logic [1:0] {
      SEL_NORMAL = 2'd0,
      SEL_JUMP   = 2'd1,
      SEL_HAZARD = 2'd2,
      SEL_BRANCH = 2'd3
   } sel_e;

   function automatic logic is_jump(input logic [31:0] w);
      return (w[31:26] == OP_J) || (w[31:26] == OP_JAL);
   endfunction

   function automatic logic reads_rt(input logic [31:0] w);
      logic r;
      case (w[31:26])
         OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: r = 1'b1;
         default:                         r = 1'b0;
      endcase
      return r;
   endfunction

   // Jumps read nothing; every other opcode reads rs, some also rt.
   function automatic logic uses_reg(input logic [31:0] w, input logic [4:0] r);
      logic hit;
      if (is_jump(w)) begin
         hit = 1'b0;
      end else begin
         hit = (w[25:21] == r) || (reads_rt(w) && (w[20:16] == r));
      end
      return hit;
   endfunction

   logic [ADDR_W-1:0] fetch_pc_q;
   logic              fetch_vld_q;
   logic [31:0]       id_ins_q, id_ins_d;
   logic [ADDR_W-1:0] id_pc_q, id_pc_d;
   logic              id_valid_q, id_valid_d;
   logic [31:0]       ex_ins_q, ex_ins_d;
   logic [ADDR_W-1:0] ex_pc_q, ex_pc_d;
   logic              ex_valid_q, ex_valid_d;

   logic ex_load_s, hz_s, jp_s, br_s;
   sel_e sel_s;

   // Priority select: branch over hazard over jump over normal flow.
   always_comb begin
      ex_load_s = ex_valid_q && (ex_ins_q[31:26] == OP_LW) && (ex_ins_q[20:16] != 5'd0);
      hz_s      = ex_load_s && id_valid_q && uses_reg(id_ins_q, ex_ins_q[20:16]);
      jp_s      = id_valid_q && is_jump(id_ins_q);
      br_s      = bus.branch_taken && ex_valid_q;
      if (br_s) begin
         sel_s = SEL_BRANCH;
      end else if (hz_s) begin
         sel_s = SEL_HAZARD;
      end else if (jp_s) begin
         sel_s = SEL_JUMP;
      end else begin
         sel_s = SEL_NORMAL;
      end
   end

   // Next contents of IF/ID and ID/EX for the selected action.
   always_comb begin
      id_ins_d   = bus.ins;
      id_pc_d    = fetch_pc_q;
      id_valid_d = fetch_vld_q;
      ex_ins_d   = id_ins_q;
      ex_pc_d    = id_pc_q;
      ex_valid_d = id_valid_q;
      case (sel_s)
         SEL_BRANCH: begin
            id_ins_d   = NOP_WORD;
            id_pc_d    = {ADDR_W{1'b0}};
            id_valid_d = 1'b0;
            ex_ins_d   = NOP_WORD;
            ex_pc_d    = {ADDR_W{1'b0}};
            ex_valid_d = 1'b0;
         end
         SEL_HAZARD: begin
            id_ins_d   = id_ins_q;
            id_pc_d    = id_pc_q;
            id_valid_d = id_valid_q;
            ex_ins_d   = NOP_WORD;
            ex_pc_d    = {ADDR_W{1'b0}};
            ex_valid_d = 1'b0;
         end
         SEL_JUMP: begin
            id_ins_d   = NOP_WORD;
            id_pc_d    = {ADDR_W{1'b0}};
            id_valid_d = 1'b0;
         end
         SEL_NORMAL: begin
            id_valid_d = fetch_vld_q;
         end
         default: begin
            id_valid_d = 1'b0;
            ex_valid_d = 1'b0;
         end
      endcase
   end

   // Pipeline and fetch-pairing registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q  <= {ADDR_W{1'b0}};
         fetch_vld_q <= 1'b0;
         id_ins_q    <= 32'h0000_0000;
         id_pc_q     <= {ADDR_W{1'b0}};
         id_valid_q  <= 1'b0;
         ex_ins_q    <= 32'h0000_0000;
         ex_pc_q     <= {ADDR_W{1'b0}};
         ex_valid_q  <= 1'b0;
      end else begin
         fetch_pc_q  <= bus.current_address;
         fetch_vld_q <= 1'b1;
         id_ins_q    <= id_ins_d;
         id_pc_q     <= id_pc_d;
         id_valid_q  <= id_valid_d;
         ex_ins_q    <= ex_ins_d;
         ex_pc_q     <= ex_pc_d;
         ex_valid_q  <= ex_valid_d;
      end
   end

   // Redirect target is the branch destination or the jump's low bits.
   always_comb begin
      case (sel_s)
         SEL_BRANCH: bus.jmp_loc = bus.branch_target;
         SEL_JUMP:   bus.jmp_loc = id_ins_q[ADDR_W-1:0];
         default:    bus.jmp_loc = {ADDR_W{1'b0}};
      endcase
   end

   assign bus.stall      = (sel_s == SEL_HAZARD);
   assign bus.stall_pm   = (sel_s == SEL_HAZARD);
   assign bus.pc_mux_sel = (sel_s == SEL_BRANCH) || (sel_s == SEL_JUMP);
   assign bus.id_ins     = id_ins_q;
   assign bus.id_pc      = id_pc_q;
   assign bus.id_valid   = id_valid_q;
   assign bus.ex_ins     = ex_ins_q;
   assign bus.ex_pc      = ex_pc_q;
   assign bus.ex_valid   = ex_valid_q;

`ifdef HAZARD_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   // Saturating event counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= {CNT_W{1'b0}};
         flush_cnt_q <= {CNT_W{1'b0}};
      end else begin
         if ((sel_s == SEL_HAZARD) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (((sel_s == SEL_BRANCH) || (sel_s == SEL_JUMP)) && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.stall_count = stall_cnt_q;
   assign bus.flush_count = flush_cnt_q;
`endif

endmodule

// File: doc/decode_hazard_unit.md
# decode_hazard_unit

Instruction-decode front end sitting directly downstream of the program-memory/fetch block. It pairs each fetched instruction with its address and holds it in the IF/ID register, then advances it into the ID/EX register. It detects load-use hazards and drives `stall`/`stall_pm` back to fetch. It resolves J/JAL redirects in decode, accepts taken-branch redirects from execute, and flushes wrong-path instructions.

## Interface
- `ADDR_W`, 16, instruction address width
- `NOP_WORD`, 32'h0000_0000, word inserted as a bubble
- `CNT_W`, 16, statistics counter width (only with `HAZARD_STATS_EN`)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `ins`  in  32  instruction from fetch; the ROM has 1-cycle latency
- `current_address`  in  ADDR_W  address fetch presents to the ROM this cycle
- `branch_taken`  in  1  execute stage resolved a taken branch for the instruction in `ex_*`
- `branch_target`  in  ADDR_W  branch destination
- `stall`  out  1  fetch re-reads the held address
- `stall_pm`  out  1  fetch re-presents the previous instruction
- `pc_mux_sel`  out  1  fetch takes `jmp_loc`
- `jmp_loc`  out  ADDR_W  redirect address
- `id_ins`, `id_pc`, `id_valid`  out  32/ADDR_W/1  IF/ID register contents
- `ex_ins`, `ex_pc`, `ex_valid`  out  32/ADDR_W/1  ID/EX register contents, consumed by execute
- `stall_count`, `flush_count`  out  CNT_W  statistics (only with `HAZARD_STATS_EN`)

## Operation
- **Fetch pairing.** `fetch_pc <= current_address` every edge. `fetch_vld` is cleared by reset and set to 1 on the first edge after release. `ins` belongs to `fetch_pc`.
- **Decode.**
  - opcode = `ins[31:26]`; rs = [25:21]; rt = [20:16].
  - J = 000010 and JAL = 000011.
  - LW = 100011.
  - R-type (000000), BEQ (000100), BNE (000101) and SW (101011) read rs and rt.
  - All other non-jump opcodes read rs only. J and JAL read no registers.
- **Load-use hazard** (`hz`) is asserted when all of the following hold:
  - `ex_valid`, and `ex_ins` is LW with rt ≠ 0;
  - `id_valid`;
  - the ID instruction reads a register equal to `ex_ins` rt.
- **Jump** (`jp`) = `id_valid` and the ID instruction is J or JAL.
- **Priority per cycle:** `branch_taken` > `hz` > `jp` > normal. The outputs below are combinational from the registers and inputs.
  - **Branch:**
    - `pc_mux_sel`=1, `jmp_loc`=`branch_target`, `stall`=`stall_pm`=0.
    - At the edge: ID ← bubble and EX ← bubble (both wrong path).
  - **Hazard:**
    - `stall`=`stall_pm`=1, `pc_mux_sel`=0.
    - At the edge: ID holds and EX ← bubble.
  - **Jump:**
    - `pc_mux_sel`=1, `jmp_loc`=`id_ins[ADDR_W-1:0]`.
    - At the edge: EX ← ID (the jump proceeds; execute writes the JAL link). ID ← bubble, because the incoming `ins` is from jump+1.
  - **Normal:** EX ← ID; ID ← {`ins`, `fetch_pc`, `fetch_vld`}.
- **Bubble definition:** instruction = `NOP_WORD`, pc = 0, valid = 0.
- **Reset:** all outputs and registers are 0, including `fetch_vld` and the counters. While reset is low, `pc_mux_sel`=`stall`=`stall_pm`=0.

## Timing
- Instruction latency: the instruction paired at edge k appears in `id_*` after edge k and in `ex_*` after edge k+1, absent stalls.
- Load-use inserts exactly 1 bubble. The hazard cannot persist past one cycle, because EX holds a bubble the next cycle.
- J/JAL costs 1 bubble; a taken branch costs 2 bubbles.
- Back-to-back jumps cannot occur, because the slot after a jump is always a bubble.
- `branch_taken` in the same cycle as `hz` or `jp`: the branch wins and no stall is issued.
- A `branch_taken` input while `ex_valid`=0 is ignored: no redirect and no flush.
- Reset is asserted asynchronously at any point; there is no partial state. The first edge after release loads an ID bubble (`fetch_vld`=0).
- `fetch_pc` keeps updating during a stall, which is consistent with fetch re-reading its hold address.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `stall_count` increments on each cycle with `hz` selected.
  - `flush_count` increments on each cycle with branch or jump selected.
  - Both saturate at all-ones and are cleared by reset.
- `HAZARD_STATS_EN` undefined: the ports and counters are absent, and the rest of the behaviour is identical.

## Test plan
- **Reset:** release reset with ins=0x8C010000 (LW) at addr 0.
  - Required: all outputs 0 during reset.
  - Required: ID valid only from the 2nd edge after release.
- **Load-use:** LW $1 at pc 4, then ADD $2,$1,$3 (0x00231020) at pc 5.
  - Required: `stall`=`stall_pm`=1 for exactly 1 cycle.
  - Required: `ex_valid`=0 for that slot, then the ADD appears in EX with `ex_pc`=5.
- **No false hazard:** LW $0 followed by an instruction reading $0, and LW $1 followed by J.
  - Required: no stall in either case.
- **Jump:** J 0x0040 at pc 8.
  - Required: `pc_mux_sel`=1 and `jmp_loc`=0x0040 for 1 cycle.
  - Required: the next ID entry is a bubble, and the ID entry after that has `id_pc`=0x0040.
- **Branch vs hazard:** `branch_taken`=1 with `branch_target`=0x0100 in the same cycle a load-use hazard exists.
  - Required: `stall`=0 and `jmp_loc`=0x0100.
  - Required: ID and EX are both bubbles after the edge.
- **Stats** (`HAZARD_STATS_EN`): 3 load-use stalls and 2 jumps.
  - Required: `stall_count`=3 and `flush_count`=2.
  - Required: a counter preloaded at 0xFFFF holds at 0xFFFF.
